// File: rtl/aobureg_prot_if.sv
// APB segment bundle for the always-on backup register file.
// Request and response halves are split into separate slave-side modports.
interface apbif;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master  (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready, pslverr);
  modport slavein (input  psel, penable, pwrite, paddr, pwdata);
  modport slave   (output prdata, pready, pslverr);
endinterface

// File: rtl/aobureg_prot.sv
// Always-on backup register bank with key-sequence unlock window, sticky
// per-register locks, sequential rotate-xor checksum and violation reporting.
module aobureg_prot #(
  parameter int unsigned REGCNT = 8,
  parameter int unsigned DW     = 32,
  parameter logic [31:0] KEYVAL = 32'h5AA5_C33C,
  parameter int unsigned WINDOW = 256
) (
  input  logic                 pclk,
  input  logic                 resetn,
  apbif.slavein                apbs,
  apbif.slave                  apbx,
  output logic [REGCNT*DW-1:0] bureg_o,
  output logic [REGCNT-1:0]    lock_o,
  output logic                 viol_irq
);

  localparam int unsigned CW   = $clog2(WINDOW + 1);
  localparam int unsigned IDXW = (REGCNT > 1) ? $clog2(REGCNT) : 1;

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_ARMED  = 2'd1,
    ST_OPEN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     data_q [REGCNT];
  logic [REGCNT-1:0] lock_q;
  logic              viol_q, viol_d;
  logic              busy_q;
  logic [IDXW-1:0]   idx_q;
  logic [DW-1:0]     acc_q;
  logic [DW-1:0]     chk_q;

  logic              access_c, wr_c;
  logic [11:0]       addr_c;
  logic [4:0]        widx_c;
  logic [IDXW-1:0]   ridx_c;
  logic              data_sel_c, lock_sel_c, key_sel_c, stat_sel_c, chk_sel_c, valid_c;
  logic              key_wr_c, key2_c;
  logic              dwr_c, dacc_c, drej_c, armed_bad_c, viol_set_c;
  logic              open_c, armed_c;
  logic [DW-1:0]     acc_step_c;

  // Address decode; unaligned or unmapped offsets fall through to an error.
  assign access_c   = apbs.psel & apbs.penable;
  assign wr_c       = access_c & apbs.pwrite;
  assign addr_c     = apbs.paddr;
  assign widx_c     = addr_c[6:2];
  assign ridx_c     = IDXW'(widx_c);
  assign data_sel_c = (addr_c[11:7] == 5'd0) && (addr_c[1:0] == 2'b00) &&
                      (6'(widx_c) < 6'(REGCNT));
  assign lock_sel_c = (addr_c == 12'h080);
  assign key_sel_c  = (addr_c == 12'h084);
  assign stat_sel_c = (addr_c == 12'h088);
  assign chk_sel_c  = (addr_c == 12'h08C);
  assign valid_c    = data_sel_c | lock_sel_c | key_sel_c | stat_sel_c | chk_sel_c;

  assign key_wr_c    = wr_c & key_sel_c;
  assign key2_c      = key_wr_c & (apbs.pwdata == ~KEYVAL);
  assign dwr_c       = wr_c & data_sel_c;
  assign dacc_c      = dwr_c & open_c & ~lock_q[ridx_c];
  assign drej_c      = dwr_c & ~dacc_c;
  assign armed_bad_c = armed_c & wr_c & ~key2_c;
  assign viol_set_c  = drej_c | armed_bad_c;

  // Unlock FSM state register.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_LOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Unlock FSM next state; decisions use the state held before the edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOCKED: if (key_wr_c && (apbs.pwdata == KEYVAL)) state_d = ST_ARMED;
      ST_ARMED:  if (wr_c) state_d = key2_c ? ST_OPEN : ST_LOCKED;
      ST_OPEN:   if (key_wr_c || (cnt_q == CW'(1))) state_d = ST_LOCKED;
      default:   state_d = ST_LOCKED;
    endcase
  end

  // Unlock FSM outputs and window counter.
  always_comb begin
    open_c  = (state_q == ST_OPEN);
    armed_c = (state_q == ST_ARMED);
    cnt_d   = cnt_q;
    if (armed_c && (state_d == ST_OPEN)) begin
      cnt_d = CW'(WINDOW);
    end else if (open_c) begin
      cnt_d = (state_d == ST_LOCKED) ? '0 : (cnt_q - CW'(1));
    end
  end

  // A fresh violation in the same cycle as a W1C clear keeps viol set.
  always_comb begin
    viol_d = viol_q;
    if (wr_c && stat_sel_c && apbs.pwdata[2]) viol_d = 1'b0;
    if (viol_set_c) viol_d = 1'b1;
  end

  assign acc_step_c = ((acc_q << 1) | (acc_q >> (DW - 1))) ^ data_q[idx_q];

  // Register bank, locks, status and checksum scan.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '{default: '0};
      lock_q <= '0;
      viol_q <= 1'b0;
      busy_q <= 1'b0;
      idx_q  <= '0;
      acc_q  <= '0;
      chk_q  <= '0;
    end else begin
      viol_q <= viol_d;
      if (dacc_c) data_q[ridx_c] <= apbs.pwdata[DW-1:0];
      if (wr_c && lock_sel_c) lock_q <= lock_q | apbs.pwdata[REGCNT-1:0];
      if (dacc_c) begin
        busy_q <= 1'b1;
        idx_q  <= '0;
        acc_q  <= '0;
      end else if (busy_q) begin
        acc_q <= acc_step_c;
        idx_q <= idx_q + IDXW'(1);
        if (idx_q == IDXW'(REGCNT - 1)) begin
          chk_q  <= acc_step_c;
          busy_q <= 1'b0;
        end
      end
    end
  end

  // Zero-wait-state response; read data follows current state directly.
  always_comb begin
    apbx.prdata = '0;
    if (data_sel_c)      apbx.prdata = 32'(data_q[ridx_c]);
    else if (lock_sel_c) apbx.prdata = 32'(lock_q);
    else if (stat_sel_c) apbx.prdata = {29'd0, viol_q, busy_q, open_c};
    else if (chk_sel_c)  apbx.prdata = 32'(chk_q);
  end

  assign apbx.pready  = 1'b1;
  assign apbx.pslverr = access_c & (~valid_c | drej_c);

  for (genvar g = 0; g < REGCNT; g++) begin : g_flat
    assign bureg_o[g*DW +: DW] = data_q[g];
  end

  assign lock_o   = lock_q;
  assign viol_irq = viol_q;

endmodule

// File: tb/tb_aobureg_prot.sv
// Directed bench for aobureg_prot: a vector table for single accesses plus
// timed sequences for the unlock window, checksum scan and mid-scan reset.
module tb_aobureg_prot;

  localparam logic [31:0] KEY1 = 32'h5AA5_C33C;
  localparam logic [31:0] KEY2 = 32'hA55A_3CC3;
  localparam logic [11:0] A_LOCK = 12'h080;
  localparam logic [11:0] A_KEY  = 12'h084;
  localparam logic [11:0] A_STAT = 12'h088;
  localparam logic [11:0] A_CHK  = 12'h08C;

  logic          pclk;
  logic          resetn;
  logic [255:0]  bureg_o;
  logic [7:0]    lock_o;
  logic          viol_irq;

  int checks   = 0;
  int failures = 0;

  apbif bus ();

  aobureg_prot dut (
    .pclk     (pclk),
    .resetn   (resetn),
    .apbs     (bus),
    .apbx     (bus),
    .bureg_o  (bureg_o),
    .lock_o   (lock_o),
    .viol_irq (viol_irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic        exp_err;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                     input logic [31:0] mask, input logic err, input logic irq,
                     input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.mask = mask;
    v.exp_err = err; v.exp_irq = irq; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = a; bus.pwdata = d;
    @(negedge pclk);
    bus.penable = 1'b1;
    #1 err = bus.pslverr;
    @(posedge pclk);
    #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
    @(negedge pclk);
    bus.penable = 1'b1;
    #1;
    d   = bus.prdata;
    err = bus.pslverr;
    @(posedge pclk);
    #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic wr_chk(input string nm, input logic [11:0] a, input logic [31:0] d,
                        input logic exp_err);
    logic e;
    apb_write(a, d, e);
    check({nm, "_err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] mask,
                        input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    check(nm, d & mask, exp);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    resetn = 1'b1;
  endtask

  task automatic unlock();
    logic e;
    apb_write(A_KEY, KEY1, e);
    apb_write(A_KEY, KEY2, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    do_reset();

    // Reset state.
    check("rst_bureg_zero", 32'(bureg_o == '0), 32'd1);
    check("rst_lock", 32'(lock_o), 32'h0);
    check("rst_irq", 32'(viol_irq), 32'h0);
    check("rst_pready", 32'(bus.pready), 32'h1);
    rd_chk("rst_status", A_STAT, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rst_chksum", A_CHK, 32'hFFFF_FFFF, 32'h0);

    // Single-access vectors: writes carry wdata, reads carry expected data.
    add(1, 12'h000, 32'h1234,      0,   1, 1, "d0_locked_wr");
    add(0, 12'h000, 32'h0,         '1,  0, 1, "d0_unchanged");
    add(0, A_STAT,  32'h4,         '1,  0, 1, "status_viol");
    add(1, A_STAT,  32'h4,         0,   0, 0, "status_w1c");
    add(0, A_STAT,  32'h0,         '1,  0, 0, "status_clear");
    add(1, A_KEY,   32'hDEADBEEF,  0,   0, 0, "badkey_locked");
    add(0, A_STAT,  32'h0,         '1,  0, 0, "badkey_noviol");
    add(0, A_KEY,   32'h0,         '1,  0, 0, "key_reads0");
    add(1, 12'h090, 32'h1,         0,   1, 0, "badaddr_wr");
    add(0, 12'h090, 32'h0,         '1,  1, 0, "badaddr_rd");
    add(0, 12'h020, 32'h0,         '1,  1, 0, "d8_oor_rd");
    add(1, A_KEY,   KEY1,          0,   0, 0, "key1");
    add(0, A_STAT,  32'h0,         '1,  0, 0, "armed_read");
    add(1, A_KEY,   KEY2,          0,   0, 0, "key2");
    add(0, A_STAT,  32'h1,         '1,  0, 0, "open_set");
    add(1, A_LOCK,  32'h4,         0,   0, 0, "lock_wr4");
    add(1, 12'h008, 32'hFF,        0,   1, 1, "d2_locked_wr");
    add(0, 12'h008, 32'h0,         '1,  0, 1, "d2_unchanged");
    add(1, 12'h00C, 32'hCAFE,      0,   0, 1, "d3_wr");
    add(0, 12'h00C, 32'hCAFE,      '1,  0, 1, "d3_rd");
    add(1, A_LOCK,  32'h0,         0,   0, 1, "lock_wr0");
    add(0, A_LOCK,  32'h4,         '1,  0, 1, "lock_sticky");
    add(0, A_STAT,  32'h5,         32'h5, 0, 1, "status_open_viol");
    add(1, A_STAT,  32'h4,         0,   0, 0, "status_w1c2");
    add(1, A_KEY,   32'h0,         0,   0, 0, "relock");
    add(0, A_STAT,  32'h0,         32'h5, 0, 0, "relocked");
    add(1, A_KEY,   KEY1,          0,   0, 0, "key1_again");
    add(1, 12'h004, 32'h77,        0,   1, 1, "armed_data_wr");
    add(0, A_STAT,  32'h4,         32'h5, 0, 1, "armed_viol");
    add(0, 12'h004, 32'h0,         '1,  0, 1, "d1_unchanged");
    add(1, A_STAT,  32'h4,         0,   0, 0, "status_w1c3");
    add(1, A_KEY,   KEY1,          0,   0, 0, "key1_third");
    add(1, A_LOCK,  32'h1,         0,   0, 1, "armed_lock_wr");
    add(0, A_LOCK,  32'h5,         '1,  0, 1, "lock_took_effect");
    add(0, A_STAT,  32'h4,         32'h5, 0, 1, "armed_lock_viol");
    add(1, A_STAT,  32'h4,         0,   0, 0, "status_w1c4");
    add(0, A_STAT,  32'h0,         32'h5, 0, 0, "final_clear");

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        apb_write(tbl[i].addr, tbl[i].data, er);
      end else begin
        apb_read(tbl[i].addr, rd, er);
        check({tbl[i].name, "_data"}, rd & tbl[i].mask, tbl[i].data);
      end
      check({tbl[i].name, "_err"}, 32'(er), 32'(tbl[i].exp_err));
      check({tbl[i].name, "_irq"}, 32'(viol_irq), 32'(tbl[i].exp_irq));
    end
    check("tbl_lock_o", 32'(lock_o), 32'h5);
    check("tbl_d3_out", bureg_o[3*32 +: 32], 32'hCAFE);
    check("tbl_d2_out", bureg_o[2*32 +: 32], 32'h0);

    // Checksum scan after a single accepted write.
    do_reset();
    unlock();
    wr_chk("cs_d0", 12'h000, 32'h1, 1'b0);
    check("cs_bureg0", bureg_o[31:0], 32'h1);
    rd_chk("cs_busy1", A_STAT, 32'h2, 32'h2);
    rd_chk("cs_old3",  A_CHK,  '1,    32'h0);
    rd_chk("cs_busy5", A_STAT, 32'h2, 32'h2);
    rd_chk("cs_busy7", A_STAT, 32'h2, 32'h2);
    rd_chk("cs_idle9", A_STAT, 32'h2, 32'h0);
    rd_chk("cs_val",   A_CHK,  '1,    32'h80);
    wr_chk("cs_d0b", 12'h000, 32'h1, 1'b0);
    @(posedge pclk);
    rd_chk("cs_busy2", A_STAT, 32'h2, 32'h2);
    rd_chk("cs_busy4", A_STAT, 32'h2, 32'h2);
    rd_chk("cs_prev6", A_CHK,  '1,    32'h80);
    rd_chk("cs_idle8", A_STAT, 32'h2, 32'h0);

    // Window expiry: last open cycle accepts, first closed cycle rejects.
    do_reset();
    unlock();
    repeat (254) @(posedge pclk);
    wr_chk("win_last", 12'h010, 32'h44, 1'b0);
    rd_chk("win_closed", A_STAT, 32'h1, 32'h0);
    rd_chk("win_d4", 12'h010, '1, 32'h44);
    unlock();
    repeat (255) @(posedge pclk);
    wr_chk("win_after", 12'h014, 32'h55, 1'b1);
    rd_chk("win_d5", 12'h014, '1, 32'h0);
    check("win_irq", 32'(viol_irq), 32'h1);

    // Scan restart, then reset in the middle of a scan.
    do_reset();
    unlock();
    wr_chk("rs_d0", 12'h000, 32'h1, 1'b0);
    @(posedge pclk);
    wr_chk("rs_d7", 12'h01C, 32'h3, 1'b0);
    rd_chk("rs_mid4",  A_CHK,  '1,    32'h0);
    rd_chk("rs_mid6",  A_CHK,  '1,    32'h0);
    rd_chk("rs_mid8",  A_CHK,  '1,    32'h0);
    rd_chk("rs_busy10", A_STAT, 32'h2, 32'h2);
    rd_chk("rs_val",   A_CHK,  '1,    32'h83);
    wr_chk("rs_lock", A_LOCK, 32'h1, 1'b0);
    wr_chk("rs_d5", 12'h014, 32'h9, 1'b0);
    wr_chk("rs_d0_locked", 12'h000, 32'h2, 1'b1);
    check("rs_pre_irq", 32'(viol_irq), 32'h1);
    check("rs_pre_lock", 32'(lock_o), 32'h1);
    @(posedge pclk);
    #3 resetn = 1'b0;
    #1;
    check("ar_bureg_zero", 32'(bureg_o == '0), 32'd1);
    check("ar_lock", 32'(lock_o), 32'h0);
    check("ar_irq", 32'(viol_irq), 32'h0);
    @(negedge pclk);
    resetn = 1'b1;
    rd_chk("ar_status", A_STAT, '1, 32'h0);
    rd_chk("ar_chk", A_CHK, '1, 32'h0);
    repeat (10) @(posedge pclk);
    rd_chk("ar_chk_late", A_CHK, '1, 32'h0);
    rd_chk("ar_d5", 12'h014, '1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aobureg_prot.md
Name: aobureg_prot

Overview:
- Parametrised always-on backup register file on APB, retaining software state across low-power transitions.
- Adds four behaviours to a plain backup register bank:
  - key-sequence write protection with a timed unlock window;
  - per-register sticky write locks;
  - a sequential checksum engine;
  - violation reporting through pslverr and an interrupt.
- Sits in the AO domain on the AO APB segment and runs on pclk.

Parameters:
REGCNT, 8, number of backup registers (1..32)
DW, 32, implemented bits per register (1..32); upper read bits return 0
KEYVAL, 32'h5AA5_C33C, first unlock key; the second key is ~KEYVAL
WINDOW, 256, unlock window length in pclk cycles (≥1)

Ports:
pclk  input  1  APB/AO clock
resetn  input  1  asynchronous active-low reset
apbs  apbif.slavein  -  APB request (psel, penable, pwrite, paddr, pwdata)
apbx  apbif.slave  -  APB response (prdata, pready, pslverr)
bureg_o  output  REGCNT*DW  flat register contents; reg i is at bits [i*DW +: DW]
lock_o  output  REGCNT  per-register lock bits
viol_irq  output  1  level interrupt, equal to STATUS.viol

Behaviour:
- One clock, pclk. Reset is asynchronous and active-low on resetn.
- Reset values: all registers 0, LOCK 0, CHKSUM 0, FSM LOCKED, window counter 0, busy 0, viol 0, all outputs 0.
- Reset asserted mid-scan or mid-window aborts immediately to the reset values.
- APB timing:
  - pready is tied to 1 (zero wait states).
  - Writes commit on the access-phase edge.
  - prdata is combinational from current state.
- Register map:
  - 0x000+4i: DATA[i], i<REGCNT, read/write.
  - 0x080: LOCK, read/write. Write is set-only (OR-in); bits clear only on reset.
  - 0x084: KEY, write-only; reads 0.
  - 0x088: STATUS, read. Bit0 open, bit1 busy, bit2 viol (write 1 to clear).
  - 0x08C: CHKSUM, read-only.
  - Any other address: read 0, pslverr=1, no effect.
- Unlock FSM:
  - LOCKED:
    - KEY write == KEYVAL goes to ARMED.
    - Any other KEY value stays LOCKED, with no violation.
  - ARMED: the next APB write of any kind decides.
    - KEY write == ~KEYVAL goes to OPEN and loads the counter with WINDOW.
    - Any other write goes to LOCKED and sets viol; that write still takes effect if it is otherwise legal.
    - Reads do not disturb ARMED.
  - OPEN:
    - Counter decrements every cycle.
    - Leaves to LOCKED on the edge where the counter goes 1→0.
    - Any KEY write also goes to LOCKED (explicit relock).
    - Data writes do not reload the counter.
- All access checks use the state registered before the edge. A DATA write in the last OPEN cycle is accepted.
- DATA[i] write acceptance:
  - Accepted only if state is OPEN and LOCK[i]=0.
  - Otherwise: data is unchanged, pslverr=1, viol is set.
- Writes to LOCK and STATUS are always allowed, independent of the FSM.
- STATUS write-1-to-clear vs. new violation in the same cycle: set wins.
- Checksum:
  - Algorithm: acc=0; for i=0..REGCNT-1: acc = rotl1(acc) ^ DATA[i], in DW bits.
  - Runs one register per cycle.
  - An accepted DATA write at edge T sets busy at T and restarts the index at 0.
  - CHKSUM updates and busy clears at edge T+REGCNT.
  - An accepted DATA write during a scan restarts the scan from 0 and uses the post-write values.
  - Until the scan completes, CHKSUM reads return the previous value.
- pwdata bits above DW are ignored.

Test Plan:
1. Out of reset, write DATA0=0x1234 with no key sequence → pslverr=1; DATA0 reads 0; STATUS=0x4; viol_irq=1. Write STATUS=0x4 → viol_irq=0.
2. Unlock sequence:
   - KEY=0x5AA5C33C, then KEY=0xA55A3CC3 → STATUS.open=1.
   - Write DATA0=1 → accepted, pslverr=0; bureg_o[31:0]=1.
   - busy stays high for 8 cycles, then CHKSUM=0x00000080 (REGCNT=8, DW=32).
3. Unlock, then idle 256 cycles → open drops. Then:
   - A DATA write in the final open cycle is accepted.
   - A DATA write one cycle later → pslverr=1.
4. Unlock; write LOCK=0x4; write DATA2=0xFF → pslverr=1, DATA2 unchanged; DATA3 write accepted. Write LOCK=0 → lock_o stays 0x4.
5. Key misuse:
   - KEY=KEYVAL, then write DATA1 → FSM LOCKED, viol=1, DATA1 unchanged.
   - KEY=0xDEADBEEF in LOCKED → no viol, state stays LOCKED.
6. Scan restart and reset:
   - Unlock; write DATA0=1, then DATA7=3 three cycles later → CHKSUM=0x83 eight cycles after the second write; no intermediate CHKSUM value is observed.
   - Assert resetn mid-scan → everything reads 0; busy=0.
